// File: rtl/fixed_weight_pkg.sv
// Shared definitions for the fixed-weight word enumerator: default sizes,
// FSM state type and the popcount / count-trailing-zeros helpers.
package fixed_weight_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CW    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fw_state_e;

  function automatic logic [DEF_CW-1:0] popcount(input logic [DEF_WIDTH-1:0] v);
    logic [DEF_CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEF_WIDTH; i++) begin
      cnt = cnt + DEF_CW'(v[i]);
    end
    return cnt;
  endfunction

  // Priority encoder: index of the lowest set bit, 0 for an all-zero word.
  function automatic logic [DEF_CW-1:0] ctz(input logic [DEF_WIDTH-1:0] v);
    logic [DEF_CW-1:0] idx;
    idx = '0;
    for (int i = DEF_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = DEF_CW'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fixed_weight_enum_gosper_next.sv
// Combinational successor step: next larger word with the same popcount,
// plus detection of the final word (top k bits set) for the latched weight k.
module gosper_next
  import fixed_weight_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic [WIDTH-1:0] v,
  input  logic [CW-1:0]    k,
  output logic [WIDTH-1:0] next,
  output logic             is_last
);

  logic [WIDTH-1:0] low_bit;
  logic [WIDTH-1:0] ripple;
  logic [WIDTH-1:0] moved;

  always_comb begin
    low_bit = v & (~v + WIDTH'(1));
    ripple  = v + low_bit;
    // Bits that fell off the carry chain are re-packed at the bottom.
    moved   = (ripple ^ v) >> 2;
    next    = ripple | (moved >> ctz(low_bit));
    is_last = (v == ~({WIDTH{1'b1}} >> k));
  end

endmodule

// File: rtl/fixed_weight_enum.sv
// Enumerates every WIDTH-bit word of a requested popcount in ascending order
// over a valid/ready stream. Define FIXED_WEIGHT_CHECK_EN to add the chk_err monitor.
module fixed_weight_enum
  import fixed_weight_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    weight,
  output logic             busy,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_last,
  output logic             done
`ifdef FIXED_WEIGHT_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  fw_state_e        state_q, state_d;
  logic [CW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] next_word;
  logic             is_last;
  logic             xfer;

  gosper_next #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_gosper_next (
    .v      (word_q),
    .k      (k_q),
    .next   (next_word),
    .is_last(is_last)
  );

  assign xfer = (state_q == RUN) && out_ready;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    word_d  = word_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (weight > CW'(WIDTH)) begin
            err_d = 1'b1;
          end else begin
            state_d = RUN;
            k_d     = weight;
            word_d  = ~({WIDTH{1'b1}} << weight);
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            word_d  = '0;
          end else begin
            word_d = next_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      word_q  <= word_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == RUN);
  assign out_word  = word_q;
  // Gate with RUN: an idle word of 0 with k=0 would otherwise look final.
  assign out_last  = (state_q == RUN) && is_last;
  assign err       = err_q;
  assign done      = done_q;

`ifdef FIXED_WEIGHT_CHECK_EN
  logic             chk_err_q, chk_err_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;

  always_comb begin
    chk_err_d   = chk_err_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    if ((state_q == IDLE) && start) begin
      have_prev_d = 1'b0;
    end
    if (xfer) begin
      if (popcount(word_q) != k_q) begin
        chk_err_d = 1'b1;
      end
      if (have_prev_q && (word_q <= prev_q)) begin
        chk_err_d = 1'b1;
      end
      prev_d      = word_q;
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_q   <= 1'b0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      chk_err_q   <= chk_err_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_fixed_weight_enum.sv
// Randomized self-checking bench for fixed_weight_enum against a brute-force
// reference that lists all WIDTH-bit values with the requested popcount.
module tb_fixed_weight_enum;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CW-1:0]    weight = '0;
  logic             busy;
  logic             err;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_word;
  logic             out_last;
  logic             done;
`ifdef FIXED_WEIGHT_CHECK_EN
  logic             chk_err;
`endif

  int vectors = 0;
  int miscompares = 0;
  int total_xfers = 0;

  always #5 clk = ~clk;

  fixed_weight_enum #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .weight   (weight),
    .busy     (busy),
    .err      (err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .out_last (out_last),
    .done     (done)
`ifdef FIXED_WEIGHT_CHECK_EN
    ,
    .chk_err  (chk_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: every value in ascending order whose number of ones is k.
  task automatic build_ref(input int k, output logic [WIDTH-1:0] exp_q[$]);
    logic [WIDTH-1:0] w;
    exp_q = {};
    for (int v = 0; v < (1 << WIDTH); v++) begin
      w = WIDTH'(v);
      if ($countones(w) == k) exp_q.push_back(w);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || done !== exp_done) begin
      miscompares++;
      $display("FAIL %s: valid=%b busy=%b last=%b done=%b, required 0 0 0 %b",
               tag, out_valid, busy, out_last, done, exp_done);
    end
  endtask

  // Runs one enumeration. ready_pct sets out_ready probability, hold_at holds
  // ready low for 3 cycles at that index, abort_at resets after that many transfers.
  task automatic run_seq(input int k, input int ready_pct, input int hold_at,
                         input int abort_at, input bit poke_start);
    logic [WIDTH-1:0] exp_q[$];
    int idx = 0;
    int held = 0;
    int cycles = 0;
    logic rdy;
    build_ref(k, exp_q);
    weight = CW'(k);
    start  = 1'b1;
    step();
    start  = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_latency k=%0d: valid=%b busy=%b, required 1 1", k, out_valid, busy);
    end
    while (idx < exp_q.size() && cycles < 2000) begin
      if (idx == abort_at) break;
      if (idx == hold_at && held < 3) begin
        rdy = 1'b0;
        held++;
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
      end
      out_ready = rdy;
      if (poke_start) begin
        start  = $urandom_range(1);
        weight = CW'($urandom_range(15));
      end
      vectors++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
          out_word !== exp_q[idx] || out_last !== (idx == exp_q.size() - 1)) begin
        miscompares++;
        $display("FAIL word k=%0d idx=%0d: valid=%b busy=%b done=%b word=%h last=%b, required 1 1 0 %h %b",
                 k, idx, out_valid, busy, done, out_word, out_last, exp_q[idx],
                 (idx == exp_q.size() - 1));
      end
      step();
      cycles++;
      if (rdy) idx++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    if (cycles >= 2000) begin
      miscompares++;
      $display("FAIL timeout k=%0d: %0d words after %0d cycles, required %0d", k, idx, cycles, exp_q.size());
      return;
    end
    if (abort_at >= 0) begin
      rst = 1'b1;
      step();
      check_idle("abort_outputs", 1'b0);
      vectors++;
      if (out_word !== '0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_word: word=%h err=%b, required 00 0", out_word, err);
      end
      rst = 1'b0;
      step();
      check_idle("abort_no_done", 1'b0);
      $display("seq k=%0d aborted after %0d transfers", k, idx);
      return;
    end
    total_xfers += idx;
    check_idle("done_pulse", 1'b1);
    step();
    check_idle("done_single", 1'b0);
`ifdef FIXED_WEIGHT_CHECK_EN
    vectors++;
    if (chk_err !== 1'b0) begin
      miscompares++;
      $display("FAIL chk_err k=%0d: got %b, required 0", k, chk_err);
    end
`endif
    $display("seq k=%0d: %0d words in %0d cycles", k, idx, cycles);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check_idle("reset", 1'b0);
    vectors++;
    if (out_word !== '0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_word: word=%h err=%b, required 00 0", out_word, err);
    end
  endtask

  task automatic test_weight2();
    run_seq(2, 100, -1, -1, 1'b0);
  endtask

  task automatic test_degenerate();
    run_seq(0, 100, -1, -1, 1'b0);
    run_seq(8, 100, -1, -1, 1'b0);
    run_seq(WIDTH * ($urandom_range(1)), 50, 0, -1, 1'b0);
  endtask

  task automatic test_err();
    for (int i = 0; i < 2; i++) begin
      weight = (i == 0) ? CW'(9) : CW'($urandom_range(15, 9));
      start  = 1'b1;
      step();
      start  = 1'b0;
      vectors++;
      if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL err_pulse w=%0d: err=%b valid=%b busy=%b, required 1 0 0", weight, err, out_valid, busy);
      end
      step();
      vectors++;
      if (err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL err_single: err=%b valid=%b busy=%b, required 0 0 0", err, out_valid, busy);
      end
    end
    run_seq(1, 100, -1, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_seq(3, 60, 1, -1, 1'b1);
  endtask

  task automatic test_abort();
    run_seq(4, 100, -1, 10, 1'b0);
    run_seq(4, 100, -1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    total_xfers = 0;
    for (int k = 0; k <= WIDTH; k++) begin
      run_seq(k, $urandom_range(100, 30), -1, -1, 1'b0);
    end
    vectors++;
    if (total_xfers !== 256) begin
      miscompares++;
      $display("FAIL sweep_total: got %0d transfers, required 256", total_xfers);
    end
  endtask

  initial begin
    test_reset();
    test_weight2();
    test_degenerate();
    test_err();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
